// File: rtl/sram_ctrl_pkg.sv
// Shared types and SRAM pin encodings for the OpenRAM request sequencer.
package sram_ctrl_pkg;

    localparam int unsigned SRAM_DATA_WIDTH = 17;
    localparam int unsigned SRAM_ADDR_WIDTH = 10;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_e;

    // OpenRAM pins are active-low
    localparam logic CS_ACTIVE = 1'b0;
    localparam logic CS_IDLE   = 1'b1;
    localparam logic WE_WRITE  = 1'b0;
    localparam logic WE_READ   = 1'b1;

endpackage

// File: rtl/sram_rsp_fifo.sv
// Response FIFO holding SRAM read data until the consumer takes it; head is shown directly.
module sram_rsp_fifo #(
    parameter int unsigned DATA_WIDTH = 17,
    parameter int unsigned RSP_DEPTH  = 4,
    localparam int unsigned PTR_W     = $clog2(RSP_DEPTH),
    localparam int unsigned CNT_W     = PTR_W + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic [CNT_W-1:0]      count_o,
    output logic                  full_o,
    output logic                  empty_o
);

    logic [DATA_WIDTH-1:0] mem_q [RSP_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [CNT_W-1:0]      count_q;

    // Storage is reset so the head reads zero while empty
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < RSP_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CNT_W'(RSP_DEPTH));
    assign empty_o = (count_q == '0);

    assert property (@(posedge clk_i) disable iff (rst_i) !(pop_i && empty_o));

endmodule

// File: rtl/sram_req_ctrl.sv
// Request sequencer for the single-port OpenRAM macro: zero-fill sweep, pin
// registers, read-return pipe and credit-gated response FIFO.
module sram_req_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = SRAM_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = SRAM_ADDR_WIDTH,
    parameter int unsigned RAM_DEPTH  = 1 << ADDR_WIDTH,
    parameter int unsigned RSP_DEPTH  = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    input  logic                  init_start,
    output logic                  init_done,
    output logic                  csb0,
    output logic                  web0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] dout0
);

    localparam int unsigned CNT_W = $clog2(RSP_DEPTH) + 1;
    localparam int unsigned CRD_W = CNT_W + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] sweep_q, sweep_d;
    logic                  csb0_q, csb0_d;
    logic                  web0_q, web0_d;
    logic [ADDR_WIDTH-1:0] addr0_q, addr0_d;
    logic [DATA_WIDTH-1:0] din0_q, din0_d;
    logic                  req_ready_q, req_ready_d;
    logic                  init_done_q, init_done_d;
    logic                  rd_p1_q, rd_p1_d;
    logic                  rd_p2_q, rd_p2_d;

    logic                  accept;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    logic [CNT_W-1:0]      fifo_count_nxt;
    logic [CRD_W-1:0]      credit_used;

    assign accept    = (state_q == ST_IDLE) && req_valid && req_ready_q;
    assign fifo_push = rd_p2_q;
    assign fifo_pop  = rsp_ready && !fifo_empty;

    always_comb begin
        state_d        = state_q;
        sweep_d        = sweep_q;
        csb0_d         = CS_IDLE;
        web0_d         = WE_READ;
        addr0_d        = addr0_q;
        din0_d         = din0_q;
        rd_p1_d        = 1'b0;
        rd_p2_d        = rd_p1_q;
        fifo_count_nxt = '0;
        credit_used    = '0;
        req_ready_d    = 1'b0;
        init_done_d    = 1'b0;

        unique case (state_q)
            ST_INIT: begin
                csb0_d  = CS_ACTIVE;
                web0_d  = WE_WRITE;
                addr0_d = sweep_q;
                din0_d  = '0;
                sweep_d = sweep_q + ADDR_WIDTH'(1);
                if (sweep_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                    sweep_d = '0;
                end
            end
            ST_IDLE: begin
                if (accept) begin
                    csb0_d  = CS_ACTIVE;
                    addr0_d = req_addr;
                    if (req_write) begin
                        web0_d = WE_WRITE;
                        din0_d = req_wdata;
                    end else begin
                        web0_d  = WE_READ;
                        rd_p1_d = 1'b1;
                    end
                end
                // The op accepted this cycle still issues before the sweep starts
                if (init_start) begin
                    state_d = ST_INIT;
                end
            end
            default: state_d = ST_INIT;
        endcase

        // Reads in the pipe plus stored responses may never exceed the FIFO size
        fifo_count_nxt = fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
        credit_used    = CRD_W'(rd_p1_d) + CRD_W'(rd_p2_d) + CRD_W'(fifo_count_nxt);
        req_ready_d    = (state_d == ST_IDLE) && (credit_used < CRD_W'(RSP_DEPTH));
        init_done_d    = (state_d == ST_IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_INIT;
            sweep_q     <= '0;
            csb0_q      <= CS_IDLE;
            web0_q      <= WE_READ;
            addr0_q     <= '0;
            din0_q      <= '0;
            req_ready_q <= 1'b0;
            init_done_q <= 1'b0;
            rd_p1_q     <= 1'b0;
            rd_p2_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sweep_q     <= sweep_d;
            csb0_q      <= csb0_d;
            web0_q      <= web0_d;
            addr0_q     <= addr0_d;
            din0_q      <= din0_d;
            req_ready_q <= req_ready_d;
            init_done_q <= init_done_d;
            rd_p1_q     <= rd_p1_d;
            rd_p2_q     <= rd_p2_d;
        end
    end

    sram_rsp_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .RSP_DEPTH  (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk_i   (clock),
        .rst_i   (reset),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i (dout0),
        .rdata_o (rsp_rdata),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign csb0      = csb0_q;
    assign web0      = web0_q;
    assign addr0     = addr0_q;
    assign din0      = din0_q;
    assign req_ready = req_ready_q;
    assign init_done = init_done_q;
    assign rsp_valid = !fifo_empty;

    assert property (@(posedge clock) disable iff (reset) !(fifo_push && fifo_full && !fifo_pop));

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Directed bench for sram_req_ctrl with a behavioural single-port SRAM attached.
module tb_sram_req_ctrl;

    localparam int unsigned AW    = 10;
    localparam int unsigned DW    = 17;
    localparam int unsigned DEPTH = 1024;

    logic          clock = 1'b0;
    logic          reset;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          init_start, init_done;
    logic          csb0, web0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] din0;
    logic [DW-1:0] dout0 = '0;

    logic [DW-1:0] sram_mem [0:DEPTH-1] = '{default: 17'h15555};
    logic [DW-1:0] exp_mem  [0:DEPTH-1];
    logic [DW-1:0] exp_q [$];

    int n_checks = 0;
    int n_fail   = 0;
    int n_acc    = 0;
    int n_rsp    = 0;

    typedef struct {
        logic          v;
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          rr;
        logic          e_csb;
        logic          e_web;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_din;
        logic          e_rv;
        logic [DW-1:0] e_rd;
    } vec_t;

    vec_t vecs [12];

    always #5 clock = ~clock;

    // Behavioural OpenRAM: latches pins at the edge, read data valid one cycle later
    always @(posedge clock) begin
        if (!csb0) begin
            if (!web0) sram_mem[addr0] <= din0;
            else       dout0 <= sram_mem[addr0];
        end
    end

    sram_req_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .RAM_DEPTH  (DEPTH),
        .RSP_DEPTH  (4)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .init_start (init_start),
        .init_done  (init_done),
        .csb0       (csb0),
        .web0       (web0),
        .addr0      (addr0),
        .din0       (din0),
        .dout0      (dout0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid = v;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
    endtask

    // Book-keep handshakes that will happen at the coming edge
    task automatic handshake();
        if (req_valid && req_ready) begin
            n_acc++;
            if (req_write) exp_mem[req_addr] = req_wdata;
            else           exp_q.push_back(exp_mem[req_addr]);
        end
        if (rsp_valid && rsp_ready) begin
            n_rsp++;
            check("rsp_pending", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) check("rsp_data", 32'(rsp_rdata), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic cycle();
        handshake();
        @(posedge clock);
        #1;
    endtask

    task automatic sweep_check(input string name, input int pulse_at);
        for (int i = 0; i < int'(DEPTH); i++) begin
            init_start = (i == pulse_at);
            cycle();
            check({name, "_pins"}, {3'b0, csb0, web0, addr0, din0}, {3'b0, 1'b0, 1'b0, AW'(i), DW'(0)});
            check({name, "_done"}, 32'(init_done), 32'(i == int'(DEPTH) - 1));
            check({name, "_ready"}, 32'(req_ready), 32'(i == int'(DEPTH) - 1));
        end
        init_start = 1'b0;
        cycle();
        check({name, "_after_csb0"}, 32'(csb0), 32'd1);
        check({name, "_after_done"}, 32'(init_done), 32'd1);
        check({name, "_after_ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int a0;
        int r0;
        reset      = 1'b1;
        rsp_ready  = 1'b0;
        init_start = 1'b0;
        drive(1'b0, 1'b0, '0, '0);
        for (int i = 0; i < int'(DEPTH); i++) exp_mem[i] = '0;

        // Reset values
        #12;
        check("rst_csb0", 32'(csb0), 32'd1);
        check("rst_web0", 32'(web0), 32'd1);
        check("rst_addr0", 32'(addr0), 32'd0);
        check("rst_din0", 32'(din0), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("rst_init_done", 32'(init_done), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        sweep_check("init_sweep", -1);

        // Directed write/read vectors; expected values are after the edge
        vecs[0]  = '{1'b1, 1'b1, 10'd5, 17'h1ABCD, 1'b1, 1'b0, 1'b0, 10'd5, 17'h1ABCD, 1'b0, 17'h0};
        vecs[1]  = '{1'b1, 1'b0, 10'd5, 17'h0,     1'b1, 1'b0, 1'b1, 10'd5, 17'h1ABCD, 1'b0, 17'h0};
        vecs[2]  = '{1'b1, 1'b0, 10'd6, 17'h0,     1'b1, 1'b0, 1'b1, 10'd6, 17'h1ABCD, 1'b0, 17'h0};
        vecs[3]  = '{1'b0, 1'b0, 10'd0, 17'h0,     1'b1, 1'b1, 1'b1, 10'd6, 17'h1ABCD, 1'b1, 17'h1ABCD};
        vecs[4]  = '{1'b0, 1'b0, 10'd0, 17'h0,     1'b1, 1'b1, 1'b1, 10'd6, 17'h1ABCD, 1'b1, 17'h0};
        vecs[5]  = '{1'b0, 1'b0, 10'd0, 17'h0,     1'b1, 1'b1, 1'b1, 10'd6, 17'h1ABCD, 1'b0, 17'h0};
        vecs[6]  = '{1'b1, 1'b1, 10'd7, 17'h1FFFF, 1'b1, 1'b0, 1'b0, 10'd7, 17'h1FFFF, 1'b0, 17'h0};
        vecs[7]  = '{1'b1, 1'b0, 10'd7, 17'h0,     1'b1, 1'b0, 1'b1, 10'd7, 17'h1FFFF, 1'b0, 17'h0};
        vecs[8]  = '{1'b0, 1'b0, 10'd0, 17'h0,     1'b1, 1'b1, 1'b1, 10'd7, 17'h1FFFF, 1'b0, 17'h0};
        vecs[9]  = '{1'b0, 1'b0, 10'd0, 17'h0,     1'b0, 1'b1, 1'b1, 10'd7, 17'h1FFFF, 1'b1, 17'h1FFFF};
        vecs[10] = '{1'b0, 1'b0, 10'd0, 17'h0,     1'b0, 1'b1, 1'b1, 10'd7, 17'h1FFFF, 1'b1, 17'h1FFFF};
        vecs[11] = '{1'b0, 1'b0, 10'd0, 17'h0,     1'b1, 1'b1, 1'b1, 10'd7, 17'h1FFFF, 1'b0, 17'h0};
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].v, vecs[i].w, vecs[i].a, vecs[i].d);
            rsp_ready = vecs[i].rr;
            if (vecs[i].v && vecs[i].w) exp_mem[vecs[i].a] = vecs[i].d;
            @(posedge clock);
            #1;
            check($sformatf("vec%0d_ready", i), 32'(req_ready), 32'd1);
            check($sformatf("vec%0d_csb0", i), 32'(csb0), 32'(vecs[i].e_csb));
            check($sformatf("vec%0d_web0", i), 32'(web0), 32'(vecs[i].e_web));
            check($sformatf("vec%0d_addr0", i), 32'(addr0), 32'(vecs[i].e_addr));
            check($sformatf("vec%0d_din0", i), 32'(din0), 32'(vecs[i].e_din));
            check($sformatf("vec%0d_rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].e_rv));
            if (vecs[i].e_rv) check($sformatf("vec%0d_rsp_rdata", i), 32'(rsp_rdata), 32'(vecs[i].e_rd));
        end
        drive(1'b0, 1'b0, '0, '0);

        // Backpressure: six reads offered with the consumer stalled
        rsp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 1'b1, AW'(10 + k), DW'(32'h100 + 10 + k));
            cycle();
        end
        rsp_ready = 1'b0;
        n_acc = 0;
        n_rsp = 0;
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 1'b0, AW'(10 + n_acc), '0);
            cycle();
        end
        check("stall_accepted", 32'(n_acc), 32'd4);
        check("stall_req_ready", 32'(req_ready), 32'd0);
        rsp_ready = 1'b1;
        for (int k = 0; k < 40 && n_rsp < 6; k++) begin
            if (n_acc < 6) drive(1'b1, 1'b0, AW'(10 + n_acc), '0);
            else           drive(1'b0, 1'b0, '0, '0);
            cycle();
        end
        check("stall_responses", 32'(n_rsp), 32'd6);
        check("stall_total_acc", 32'(n_acc), 32'd6);

        // Full FIFO drained while a continuous read stream is offered
        rsp_ready = 1'b0;
        n_acc = 0;
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 1'b0, AW'(10 + (n_acc % 6)), '0);
            cycle();
        end
        check("full_rsp_valid", 32'(rsp_valid), 32'd1);
        check("full_req_ready", 32'(req_ready), 32'd0);
        rsp_ready = 1'b1;
        a0 = 0;
        r0 = 0;
        for (int k = 0; k < 24; k++) begin
            if (k == 4) begin
                a0 = n_acc;
                r0 = n_rsp;
            end
            drive(1'b1, 1'b0, AW'(10 + (n_acc % 6)), '0);
            cycle();
            if (k == 19) begin
                check("stream_accepts", 32'(n_acc - a0), 32'd16);
                check("stream_pops", 32'(n_rsp - r0), 32'd16);
            end
        end
        drive(1'b0, 1'b0, '0, '0);
        for (int k = 0; k < 20 && exp_q.size() > 0; k++) cycle();
        check("stream_drained", 32'(exp_q.size()), 32'd0);

        // init_start with two reads in flight; a second pulse mid-sweep is ignored
        n_rsp = 0;
        drive(1'b1, 1'b0, 10'd10, '0);
        cycle();
        drive(1'b1, 1'b0, 10'd11, '0);
        init_start = 1'b1;
        cycle();
        init_start = 1'b0;
        drive(1'b0, 1'b0, '0, '0);
        for (int i = 0; i < int'(DEPTH); i++) exp_mem[i] = '0;
        check("istart_req_ready", 32'(req_ready), 32'd0);
        check("istart_init_done", 32'(init_done), 32'd0);
        check("istart_last_op", {22'b0, csb0, web0, addr0}, {22'b0, 1'b0, 1'b1, 10'd11});
        sweep_check("rerun_sweep", 500);
        check("istart_responses", 32'(n_rsp), 32'd2);
        drive(1'b1, 1'b0, 10'd5, '0);
        cycle();
        drive(1'b0, 1'b0, '0, '0);
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) cycle();
        check("post_init_read5_done", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of a sweep with responses parked in the FIFO
        rsp_ready = 1'b0;
        drive(1'b1, 1'b0, 10'd7, '0);
        cycle();
        cycle();
        drive(1'b0, 1'b0, '0, '0);
        cycle();
        cycle();
        cycle();
        check("park_rsp_valid", 32'(rsp_valid), 32'd1);
        init_start = 1'b1;
        cycle();
        init_start = 1'b0;
        for (int k = 0; k < 1100; k++) begin
            cycle();
            if (!csb0 && addr0 == 10'd300) break;
        end
        check("mid_sweep_addr", 32'(addr0), 32'd300);
        check("mid_sweep_fifo_kept", 32'(rsp_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_csb0", 32'(csb0), 32'd1);
        check("async_rst_web0", 32'(web0), 32'd1);
        check("async_rst_addr0", 32'(addr0), 32'd0);
        check("async_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("async_rst_init_done", 32'(init_done), 32'd0);
        exp_q.delete();
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        sweep_check("reset_sweep", -1);
        check("reset_fifo_discarded", 32'(rsp_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
